zero_cross_freq_meter: RTL and testbench

Parametrised zero-crossing frequency meter for the audio tuner path. It counts rising zero crossings of a signed codec sample stream over a gate window measured in accepted samples, not clock cycles. The window is WINDOW samples, so at 48 kHz with WINDOW=48000 the result is in Hz. A Schmitt-style hysteresis band rejects noise near zero. It supports one-shot and continuous measurement, and reports each result with a one-cycle valid strobe and a saturation flag. It sits between the audio codec read interface and the HEX display/decoder logic.

---
 rtl/zero_cross_freq_meter_pkg.sv | 7 +
 rtl/zero_cross_freq_meter_if.sv | 22 ++
 rtl/zero_cross_freq_meter_schmitt.sv | 31 +++
 rtl/zero_cross_freq_meter.sv | 100 ++++++++++
 tb/tb_zero_cross_freq_meter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zero_cross_freq_meter_pkg.sv
// freq_meter_pkg: shared state/polarity types and constants for the zero-crossing frequency meter.
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;
  typedef enum logic {NEG, POS} polarity_t;
  localparam int AUDIO_FS = 48000;
  localparam int DEFAULT_HYST = 256;
endpackage

// File: rtl/zero_cross_freq_meter_if.sv
// zero_cross_freq_meter_if: sample/control inputs and measurement outputs of the frequency meter.
interface zero_cross_freq_meter_if #(
  parameter int SAMPLE_W = 24,
  parameter int COUNT_W = 16
);
  logic sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic start;
  logic continuous;
  logic [COUNT_W-1:0] freq;
  logic freq_valid;
  logic busy;
  logic overflow;
  modport master (
    output sample_valid, sample, start, continuous,
    input freq, freq_valid, busy, overflow
  );
  modport slave (
    input sample_valid, sample, start, continuous,
    output freq, freq_valid, busy, overflow
  );
endinterface

// File: rtl/zero_cross_freq_meter_schmitt.sv
// schmitt_crossing_detector: hysteresis polarity tracker with a NEG->POS crossing pulse.
module schmitt_crossing_detector
  import freq_meter_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int HYST = DEFAULT_HYST
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sample_valid,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic i_init,
  output polarity_t o_polarity,
  output logic o_rise
);
  localparam logic signed [SAMPLE_W-1:0] HI = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] LO = SAMPLE_W'(-HYST);
  polarity_t r_pol;
  logic w_hi;
  logic w_lo;
  assign w_hi = i_sample >= HI;
  assign w_lo = i_sample <= LO;
  assign o_polarity = r_pol;
  // The init sample only seeds polarity from its sign; it can never count as a crossing.
  assign o_rise = i_sample_valid && !i_init && r_pol == NEG && w_hi;
  always_ff @(posedge clock) begin
    if (reset) r_pol <= POS;
    else if (i_sample_valid)
      r_pol <= i_init ? (i_sample[SAMPLE_W-1] ? NEG : POS) : w_hi ? POS : w_lo ? NEG : r_pol;
  end
endmodule

// File: rtl/zero_cross_freq_meter.sv
// zero_cross_freq_meter: counts rising zero crossings over a window of accepted samples.
module zero_cross_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int COUNT_W = 16,
  parameter int WINDOW = 48000,
  parameter int HYST = DEFAULT_HYST
) (
  input logic clock,
  input logic reset,
  zero_cross_freq_meter_if.slave io_bus
);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  state_t r_state, w_next;
  logic [WIN_W-1:0] r_win, w_win, w_win_inc;
  logic [COUNT_W-1:0] r_cnt, w_cnt, w_cnt_new, r_freq, w_freq;
  logic r_sat, w_sat, w_sat_new, r_ov, w_ov, r_fv, w_fv;
  logic w_active, w_rise, w_cross;
  polarity_t w_pol;
  assign w_active = io_bus.sample_valid && r_state != IDLE;
  schmitt_crossing_detector #(
    .SAMPLE_W(SAMPLE_W),
    .HYST(HYST)
  ) u_det (
    .clock(clock),
    .reset(reset),
    .i_sample_valid(w_active),
    .i_sample(io_bus.sample),
    .i_init(r_state == ARM),
    .o_polarity(w_pol),
    .o_rise(w_rise)
  );
  assign w_cross = w_rise && w_pol == NEG;
  assign w_win_inc = r_win + 1'b1;
  // A crossing at full scale is dropped from the count but remembered as saturation.
  assign w_cnt_new = (w_cross && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  assign w_sat_new = r_sat || (w_cross && r_cnt == CNT_MAX);
  always_comb begin
    w_next = r_state;
    w_win = r_win;
    w_cnt = r_cnt;
    w_sat = r_sat;
    w_freq = r_freq;
    w_ov = r_ov;
    w_fv = 1'b0;
    case (r_state)
      IDLE: w_next = (io_bus.start || io_bus.continuous) ? ARM : IDLE;
      ARM: begin
        if (io_bus.sample_valid) begin
          w_next = GATE;
          w_win = '0;
          w_cnt = '0;
          w_sat = 1'b0;
        end
      end
      GATE: begin
        if (io_bus.sample_valid && w_win_inc == WIN_LAST) begin
          w_freq = w_cnt_new;
          w_ov = w_sat_new;
          w_fv = 1'b1;
          w_win = '0;
          w_cnt = '0;
          w_sat = 1'b0;
          w_next = io_bus.continuous ? GATE : IDLE;
        end else if (io_bus.sample_valid) begin
          w_win = w_win_inc;
          w_cnt = w_cnt_new;
          w_sat = w_sat_new;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_win <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_freq <= '0;
      r_ov <= 1'b0;
      r_fv <= 1'b0;
    end else begin
      r_state <= w_next;
      r_win <= w_win;
      r_cnt <= w_cnt;
      r_sat <= w_sat;
      r_freq <= w_freq;
      r_ov <= w_ov;
      r_fv <= w_fv;
    end
  end
  assign io_bus.freq = r_freq;
  assign io_bus.overflow = r_ov;
  assign io_bus.freq_valid = r_fv;
  assign io_bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// tb_zero_cross_freq_meter: scoreboard bench driving a 16-bit and a 4-bit counter meter in lockstep.
module tb_zero_cross_freq_meter;
  typedef struct {int fa; int oa; int fb; int ob;} exp_t;
  typedef struct {int fa; int oa; int va; int fb; int ob; int vb; int cyc;} obs_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  zero_cross_freq_meter_if #(.SAMPLE_W(24), .COUNT_W(16)) ifa ();
  zero_cross_freq_meter_if #(.SAMPLE_W(24), .COUNT_W(4)) ifb ();
  zero_cross_freq_meter #(.SAMPLE_W(24), .COUNT_W(16), .WINDOW(48), .HYST(256)) dut_a (
    .clock(clock), .reset(reset), .io_bus(ifa)
  );
  zero_cross_freq_meter #(.SAMPLE_W(24), .COUNT_W(4), .WINDOW(48), .HYST(256)) dut_b (
    .clock(clock), .reset(reset), .io_bus(ifb)
  );
  always @(negedge clock)
    if (ifa.freq_valid || ifb.freq_valid)
      obs_q.push_back('{int'(ifa.freq), int'(ifa.overflow), int'(ifa.freq_valid),
                        int'(ifb.freq), int'(ifb.overflow), int'(ifb.freq_valid), cyc});
  function automatic logic signed [23:0] pat(input int kind, input int k);
    int m;
    m = k % 8;
    case (kind)
      0: return (m < 4) ? -24'sd1000 : 24'sd1000;
      1: return (m == 3) ? -24'sd1000 : (m == 7) ? 24'sd1000 :
                (m < 3) ? ((m % 2 == 0) ? -24'sd100 : 24'sd100) :
                          ((m % 2 == 0) ? 24'sd100 : -24'sd100);
      2: return (k % 2 == 1) ? 24'sd100 : -24'sd100;
      default: return (k % 2 == 1) ? 24'sd1000 : -24'sd1000;
    endcase
  endfunction
  task automatic tick(input logic v, input logic signed [23:0] s, input logic st, input logic co);
    ifa.sample_valid = v;
    ifa.sample = s;
    ifa.start = st;
    ifa.continuous = co;
    ifb.sample_valid = v;
    ifb.sample = s;
    ifb.start = st;
    ifb.continuous = co;
    @(posedge clock);
    #1;
  endtask
  task automatic feed(input int kind, input int k0, input int n, input int gap, input logic co);
    for (int k = k0; k < k0 + n; k++) begin
      repeat (gap) tick(1'b0, '0, 1'b0, co);
      tick(1'b1, pat(kind, k), 1'b0, co);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ifa.freq !== 16'd0 || ifb.freq !== 4'd0) begin
      errors++;
      $display("FAIL reset_freq got a=%0d b=%0d want 0", ifa.freq, ifb.freq);
    end
    checks++;
    if (ifa.freq_valid !== 1'b0 || ifb.freq_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got a=%0b b=%0b want 0", ifa.freq_valid, ifb.freq_valid);
    end
    checks++;
    if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got a=%0b b=%0b want 0", ifa.busy, ifb.busy);
    end
    checks++;
    if (ifa.overflow !== 1'b0 || ifb.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got a=%0b b=%0b want 0", ifa.overflow, ifb.overflow);
    end
    reset = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic test_square;
    exp_t e;
    obs_t o;
    exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL square_busy_rise got=%0b want=1", ifa.busy);
    end
    feed(0, 0, 49, 0, 1'b0);
    checks++;
    if (ifa.freq_valid !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL square_done_edge got fv=%0b busy=%0b want fv=1 busy=0", ifa.freq_valid, ifa.busy);
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL square_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.oa != e.oa || o.fb != e.fb || o.ob != e.ob || o.va != 1 || o.vb != 1) begin
        errors++;
        $display("FAIL square_result got a=%0d/%0d b=%0d/%0d want a=%0d/%0d b=%0d/%0d",
                 o.fa, o.oa, o.fb, o.ob, e.fa, e.oa, e.fb, e.ob);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_noise;
    exp_t e;
    obs_t o;
    exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(1, 0, 49, 0, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    exp_q.push_back('{0, 0, 0, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(2, 0, 49, 0, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL noise_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.oa != e.oa || o.fb != e.fb || o.ob != e.ob) begin
        errors++;
        $display("FAIL noise_result got a=%0d/%0d b=%0d/%0d want a=%0d/%0d b=%0d/%0d",
                 o.fa, o.oa, o.fb, o.ob, e.fa, e.oa, e.fb, e.ob);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_saturation;
    exp_t e;
    obs_t o;
    exp_q.push_back('{24, 0, 15, 1});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(3, 0, 49, 0, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ifb.overflow !== 1'b1 || ifb.freq !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold got freq=%0d ov=%0b want freq=15 ov=1", ifb.freq, ifb.overflow);
    end
    exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(0, 0, 49, 0, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sat_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.oa != e.oa || o.fb != e.fb || o.ob != e.ob) begin
        errors++;
        $display("FAIL sat_result got a=%0d/%0d b=%0d/%0d want a=%0d/%0d b=%0d/%0d",
                 o.fa, o.oa, o.fb, o.ob, e.fa, e.oa, e.fb, e.ob);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_continuous;
    exp_t e;
    obs_t o;
    int last_cyc;
    bit first;
    repeat (4) exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b0, 1'b1);
    feed(0, 0, 145, 2, 1'b1);
    feed(0, 145, 16, 2, 1'b1);
    feed(0, 161, 32, 2, 1'b0);
    feed(0, 193, 8, 2, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_idle got busy a=%0b b=%0b want 0", ifa.busy, ifb.busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cont_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    first = 1'b1;
    last_cyc = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.oa != e.oa || o.fb != e.fb || o.ob != e.ob) begin
        errors++;
        $display("FAIL cont_result got a=%0d/%0d b=%0d/%0d want a=%0d/%0d b=%0d/%0d",
                 o.fa, o.oa, o.fb, o.ob, e.fa, e.oa, e.fb, e.ob);
      end
      if (!first) begin
        checks++;
        if (o.cyc - last_cyc != 144) begin
          errors++;
          $display("FAIL cont_period got=%0d want=144", o.cyc - last_cyc);
        end
      end
      first = 1'b0;
      last_cyc = o.cyc;
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_reset_abort;
    exp_t e;
    obs_t o;
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(0, 0, 21, 0, 1'b0);
    reset = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ifa.freq !== 16'd0 || ifa.busy !== 1'b0 || ifa.freq_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got freq=%0d busy=%0b fv=%0b want 0/0/0", ifa.freq, ifa.busy, ifa.freq_valid);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_result got pulses=%0d want=0", obs_q.size());
    end
    obs_q.delete();
    exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(0, 0, 49, 0, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_restart_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.fb != e.fb) begin
        errors++;
        $display("FAIL abort_restart_result got a=%0d b=%0d want a=%0d b=%0d", o.fa, o.fb, e.fa, e.fb);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_start_in_gate;
    exp_t e;
    obs_t o;
    exp_q.push_back('{6, 0, 6, 0});
    tick(1'b0, '0, 1'b1, 1'b0);
    feed(0, 0, 11, 0, 1'b0);
    tick(1'b1, pat(0, 11), 1'b1, 1'b0);
    feed(0, 12, 36, 0, 1'b0);
    checks++;
    if (ifa.freq_valid !== 1'b0) begin
      errors++;
      $display("FAIL gate_start_early got fv=%0b want=0", ifa.freq_valid);
    end
    feed(0, 48, 1, 0, 1'b0);
    checks++;
    if (ifa.freq_valid !== 1'b1) begin
      errors++;
      $display("FAIL gate_start_len got fv=%0b want=1", ifa.freq_valid);
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL gate_start_rearm got busy=%0b want=0", ifa.busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gate_start_pulses got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.fa != e.fa || o.fb != e.fb || o.oa != e.oa) begin
        errors++;
        $display("FAIL gate_start_result got a=%0d/%0d b=%0d want a=%0d/%0d b=%0d",
                 o.fa, o.oa, o.fb, e.fa, e.oa, e.fb);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  initial begin
    ifa.sample_valid = 1'b0;
    ifa.sample = '0;
    ifa.start = 1'b0;
    ifa.continuous = 1'b0;
    ifb.sample_valid = 1'b0;
    ifb.sample = '0;
    ifb.start = 1'b0;
    ifb.continuous = 1'b0;
    test_reset();
    test_square();
    test_noise();
    test_saturation();
    test_continuous();
    test_reset_abort();
    test_start_in_gate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
